rs_issue_select: RTL and testbench
==================================

Name: rs_issue_select

Overview:
- Issue stage directly downstream of the RS_entry array.
- Each cycle, picks one ready, busy reservation-station entry using a round-robin arbiter.
- Latches the chosen entry's issue packet into a single-slot issue register that feeds the functional unit, with valid/ready backpressure.
- Pulses the matching per-entry clear so the entry frees on the next edge.

Parameters:
- NUM_RS, 8, number of RS entries arbitrated (power of two, ≥2).
- PKT_W, 128, width of one flattened issue packet.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- rs_busy  in  NUM_RS  per-entry busy from RS entries.
- rs_ready  in  NUM_RS  per-entry operands-ready from RS entries.
- rs_packet  in  NUM_RS*PKT_W  entry i packet at bits [i*PKT_W +: PKT_W].
- fu_ready  in  1  FU accepts is_packet this cycle when is_valid=1.
- squash  in  1  pipeline flush (branch mispredict).
- rs_clear  out  NUM_RS  one-hot combinational clear to the granted entry.
- is_valid  out  1  issue register holds a valid packet.
- is_packet  out  PKT_W  registered issue packet.
- is_rs_idx  out  $clog2(NUM_RS)  source entry index of is_packet.
- stall_cnt  out  CNT_W  count of cycles with is_valid=1 and fu_ready=0, saturating.

Behaviour:
- Request vector: req[i] = rs_busy[i] & rs_ready[i].
- load_en = (~is_valid | fu_ready) & ~squash.
- Arbiter:
  - Round-robin starting at rr_ptr, scanning rr_ptr, rr_ptr+1, … mod NUM_RS.
  - First set req bit wins (grant_idx); grant_any = |req.
- rs_clear = onehot(grant_idx) when grant_any & load_en, else 0. It is purely combinational, so the entry sees clear in the same cycle its packet is captured.
- Issue register update on the rising edge:
  - squash=1: is_valid←0. is_packet and is_rs_idx hold. No grant.
  - Else if load_en & grant_any: is_valid←1, is_packet←rs_packet[grant_idx], is_rs_idx←grant_idx.
  - Else if load_en & ~grant_any: is_valid←0 (a consumed packet drains).
  - Else (is_valid=1, fu_ready=0): all hold. Backpressure keeps is_packet stable.
- Latency: entry ready at cycle t with register free → is_valid=1 at t+1. Throughput is one issue per cycle while fu_ready=1.
- rr_ptr:
  - Updates to (grant_idx+1) mod NUM_RS only on a committed grant (rs_clear≠0).
  - Otherwise holds. Wrap-around from NUM_RS-1 to 0 is natural modular.
- stall_cnt:
  - Increments each cycle with is_valid=1 & fu_ready=0 & ~squash.
  - Saturates at all-ones.
  - Cleared only by reset.
- Simultaneous cases:
  - fu_ready=1 with a new grant: old packet is consumed and the new one loads in the same edge (no bubble).
  - squash with fu_ready=1: squash wins; no clear is emitted.
  - An entry with rs_ready=1 but rs_busy=0 is never granted.
- Reset (reset=0, any time, asynchronous): is_valid=0, is_packet=0, is_rs_idx=0, rr_ptr=0, stall_cnt=0. rs_clear is 0 while reset is asserted.
- No X propagation: is_packet is only written from a granted entry.

Test Plan:
- Single entry: rs_busy=8'h04, rs_ready=8'h04, fu_ready=1 → rs_clear=8'h04 in that cycle; next edge is_valid=1, is_rs_idx=2, is_packet=entry 2 packet; rr_ptr=3.
- Round-robin fairness: req=8'h81 held for 4 cycles, fu_ready=1, rr_ptr=0 → grants 0,7,0,7; rs_clear alternates 8'h01/8'h80.
- Backpressure: is_valid=1, fu_ready=0 for 3 cycles with req=8'h10 → rs_clear=0, is_packet unchanged, stall_cnt=3; fu_ready=1 → rs_clear=8'h10, next edge is_rs_idx=4.
- Drain: req=0, is_valid=1, fu_ready=1 → next edge is_valid=0, rs_clear=0.
- Squash: is_valid=1, req=8'h02, squash=1 → rs_clear=0, next edge is_valid=0, rr_ptr unchanged.
- Async reset: drop reset mid-cycle while is_valid=1 and stall_cnt=5 → is_valid=0 and stall_cnt=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/rs_issue_select_if.sv
// Issue-select bundle: RS entry array side, functional-unit side, and the stall counter.
interface rs_issue_select_if #(
  parameter int NUM_RS = 8,
  parameter int PKT_W  = 128,
  parameter int CNT_W  = 16
);
  localparam int IDX_W = $clog2(NUM_RS);

  logic [NUM_RS-1:0]       rs_busy;
  logic [NUM_RS-1:0]       rs_ready;
  logic [NUM_RS*PKT_W-1:0] rs_packet;
  logic                    fu_ready;
  logic                    squash;
  logic [NUM_RS-1:0]       rs_clear;
  logic                    is_valid;
  logic [PKT_W-1:0]        is_packet;
  logic [IDX_W-1:0]        is_rs_idx;
  logic [CNT_W-1:0]        stall_cnt;

  modport master (
    output rs_busy, rs_ready, rs_packet, fu_ready, squash,
    input  rs_clear, is_valid, is_packet, is_rs_idx, stall_cnt
  );

  modport slave (
    input  rs_busy, rs_ready, rs_packet, fu_ready, squash,
    output rs_clear, is_valid, is_packet, is_rs_idx, stall_cnt
  );
endinterface

// File: rtl/rs_issue_select.sv
// Round-robin pick of one ready RS entry per cycle into a single-slot issue register
// with valid/ready backpressure, same-cycle entry clear and a saturating stall counter.
module rs_sel_lane (
  input  logic busy_i,
  input  logic ready_i,
  input  logic sel_i,
  input  logic commit_i,
  output logic req_o,
  output logic clr_o
);
  assign req_o = busy_i & ready_i;
  assign clr_o = sel_i & commit_i;
endmodule

module rs_issue_select #(
  parameter int NUM_RS = 8,
  parameter int PKT_W  = 128,
  parameter int CNT_W  = 16,
  localparam int IDX_W = $clog2(NUM_RS)
) (
  input  logic               clock,
  input  logic               reset,
  rs_issue_select_if.slave   bus
);
  logic [NUM_RS-1:0] req, req_hi, sel_oh;
  logic [IDX_W-1:0]  hi_idx, lo_idx, grant_idx;
  logic              grant_any, load_en, commit, stall_inc;

  logic              valid_q, valid_d;
  logic [PKT_W-1:0]  pkt_q, pkt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [CNT_W-1:0]  stall_q, stall_d;

  assign load_en   = (~valid_q | bus.fu_ready) & ~bus.squash;
  // Reset gating keeps entries from freeing while the issue register is held in reset.
  assign commit    = grant_any & load_en & reset;
  assign stall_inc = valid_q & ~bus.fu_ready & ~bus.squash & ~(&stall_q);

  for (genvar i = 0; i < NUM_RS; i++) begin : g_lane
    assign sel_oh[i] = (grant_idx == IDX_W'(i));
    assign req_hi[i] = req[i] & (IDX_W'(i) >= rr_q);
    rs_sel_lane u_lane (
      .busy_i  (bus.rs_busy[i]),
      .ready_i (bus.rs_ready[i]),
      .sel_i   (sel_oh[i]),
      .commit_i(commit),
      .req_o   (req[i]),
      .clr_o   (bus.rs_clear[i])
    );
  end

  // Lowest request at or above rr_q wins; otherwise wrap to the lowest request overall.
  always_comb begin
    hi_idx = '0;
    lo_idx = '0;
    for (int i = NUM_RS - 1; i >= 0; i--) begin
      if (req_hi[i]) hi_idx = IDX_W'(i);
      if (req[i])    lo_idx = IDX_W'(i);
    end
    grant_any = |req;
    grant_idx = (|req_hi) ? hi_idx : lo_idx;
  end

  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    stall_d = stall_q;
    if (stall_inc) stall_d = stall_q + 1'b1;
    if (bus.squash) begin
      valid_d = 1'b0;
    end else if (load_en) begin
      valid_d = grant_any;
      if (grant_any) begin
        pkt_d = bus.rs_packet[grant_idx*PKT_W +: PKT_W];
        idx_d = grant_idx;
        rr_d  = grant_idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
      idx_q   <= '0;
      rr_q    <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      stall_q <= stall_d;
    end
  end

  assign bus.is_valid  = valid_q;
  assign bus.is_packet = pkt_q;
  assign bus.is_rs_idx = idx_q;
  assign bus.stall_cnt = stall_q;
endmodule

// File: tb/tb_rs_issue_select.sv
// Scoreboard bench for rs_issue_select: a behavioural model predicts clear and issue state per cycle.
module tb_rs_issue_select;
  localparam int NUM_RS = 8;
  localparam int PKT_W  = 128;
  localparam int CNT_W  = 4;
  localparam int IDX_W  = $clog2(NUM_RS);

  typedef struct {
    logic [NUM_RS-1:0] clr;
    logic              v;
    logic [IDX_W-1:0]  idx;
    logic [PKT_W-1:0]  pkt;
    logic [CNT_W-1:0]  st;
  } exp_t;

  logic clock, reset;
  int   checks, failures;
  exp_t sb[$];
  exp_t e;
  logic [NUM_RS-1:0] got_clr;
  logic [PKT_W-1:0]  pk [NUM_RS];

  logic              m_valid;
  logic [PKT_W-1:0]  m_pkt;
  logic [IDX_W-1:0]  m_idx;
  int                m_rr;
  logic [CNT_W-1:0]  m_stall;

  rs_issue_select_if #(.NUM_RS(NUM_RS), .PKT_W(PKT_W), .CNT_W(CNT_W)) ifc ();

  rs_issue_select #(.NUM_RS(NUM_RS), .PKT_W(PKT_W), .CNT_W(CNT_W)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (ifc)
  );

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_pkts();
    for (int i = 0; i < NUM_RS; i++) begin
      pk[i] = {$urandom, $urandom, $urandom, $urandom};
      ifc.rs_packet[i*PKT_W +: PKT_W] = pk[i];
    end
  endtask

  // Drive one cycle, predict its outcome, capture the combinational clear, then cross the edge.
  task automatic step(input logic [NUM_RS-1:0] b, input logic [NUM_RS-1:0] r, input logic f, input logic s);
    logic [NUM_RS-1:0] req;
    logic any, ld;
    int gi;
    exp_t x;
    ifc.rs_busy = b; ifc.rs_ready = r; ifc.fu_ready = f; ifc.squash = s;
    req = b & r;
    ld  = (!m_valid || f) && !s;
    any = 0; gi = 0;
    for (int k = 0; k < NUM_RS; k++) begin
      int j;
      j = (m_rr + k) % NUM_RS;
      if (!any && req[j]) begin any = 1; gi = j; end
    end
    x.clr = '0;
    if (any && ld) x.clr[gi] = 1'b1;
    if (m_valid && !f && !s && m_stall != '1) m_stall = m_stall + 1'b1;
    if (s) m_valid = 0;
    else if (ld && any) begin
      m_valid = 1; m_pkt = pk[gi]; m_idx = IDX_W'(gi); m_rr = (gi + 1) % NUM_RS;
    end else if (ld) m_valid = 0;
    x.v = m_valid; x.idx = m_idx; x.pkt = m_pkt; x.st = m_stall;
    sb.push_back(x);
    #2;
    got_clr = ifc.rs_clear;
    tick();
    e = sb.pop_front();
  endtask

  task automatic do_reset();
    reset = 0;
    ifc.rs_busy = '1; ifc.rs_ready = '1; ifc.fu_ready = 1; ifc.squash = 0;
    #2;
    checks++;
    if (ifc.rs_clear !== '0) begin
      failures++; $display("FAIL reset_clear got=%h exp=00", ifc.rs_clear);
    end
    checks++;
    if ({ifc.is_valid, ifc.is_rs_idx, ifc.stall_cnt} !== '0 || ifc.is_packet !== '0) begin
      failures++; $display("FAIL reset_state got v=%b idx=%0d st=%0d pkt=%h exp all zero",
        ifc.is_valid, ifc.is_rs_idx, ifc.stall_cnt, ifc.is_packet);
    end
    @(posedge clock); #1;
    ifc.rs_busy = '0; ifc.rs_ready = '0; ifc.fu_ready = 0;
    reset = 1;
    m_valid = 0; m_pkt = '0; m_idx = '0; m_rr = 0; m_stall = '0;
    sb.delete();
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    step(8'h04, 8'h04, 1, 0);
    checks++; if (got_clr !== 8'h04) begin failures++; $display("FAIL single_clear got=%h exp=04", got_clr); end
    checks++; if (ifc.is_valid !== 1'b1 || ifc.is_rs_idx !== 3'd2 || ifc.is_packet !== pk[2]) begin
      failures++; $display("FAIL single_issue got v=%b idx=%0d exp v=1 idx=2", ifc.is_valid, ifc.is_rs_idx); end
    // rr now 3: requests at 1 and 5 should pick 5 first
    step(8'h22, 8'h22, 1, 0);
    checks++; if (got_clr !== e.clr || got_clr !== 8'h20) begin failures++; $display("FAIL single_rr got=%h exp=20", got_clr); end
    checks++; if (ifc.is_rs_idx !== e.idx || ifc.is_packet !== e.pkt) begin
      failures++; $display("FAIL single_rr_issue got idx=%0d exp=%0d", ifc.is_rs_idx, e.idx); end
  endtask

  task automatic test_round_robin();
    logic [NUM_RS-1:0] tbl [4];
    tbl = '{8'h01, 8'h80, 8'h01, 8'h80};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(8'h81, 8'hFF, 1, 0);
      checks++; if (got_clr !== tbl[i] || got_clr !== e.clr) begin
        failures++; $display("FAIL rr_clear[%0d] got=%h exp=%h", i, got_clr, tbl[i]); end
      checks++; if (ifc.is_valid !== e.v || ifc.is_rs_idx !== e.idx || ifc.is_packet !== e.pkt) begin
        failures++; $display("FAIL rr_issue[%0d] got v=%b idx=%0d exp v=%b idx=%0d", i, ifc.is_valid, ifc.is_rs_idx, e.v, e.idx); end
    end
  endtask

  task automatic test_backpressure();
    logic [PKT_W-1:0] held;
    do_reset();
    step(8'h10, 8'h10, 1, 0);
    held = ifc.is_packet;
    checks++; if (held !== pk[4]) begin failures++; $display("FAIL bp_load got=%h exp=%h", held, pk[4]); end
    for (int i = 0; i < 3; i++) begin
      step(8'h10, 8'h10, 0, 0);
      checks++; if (got_clr !== 8'h00) begin failures++; $display("FAIL bp_clear[%0d] got=%h exp=00", i, got_clr); end
      checks++; if (ifc.is_valid !== 1'b1 || ifc.is_packet !== held || ifc.stall_cnt !== e.st) begin
        failures++; $display("FAIL bp_hold[%0d] got v=%b st=%0d exp v=1 st=%0d", i, ifc.is_valid, ifc.stall_cnt, e.st); end
    end
    checks++; if (ifc.stall_cnt !== 4'd3) begin failures++; $display("FAIL bp_stall got=%0d exp=3", ifc.stall_cnt); end
    step(8'h10, 8'h10, 1, 0);
    checks++; if (got_clr !== 8'h10) begin failures++; $display("FAIL bp_release_clear got=%h exp=10", got_clr); end
    checks++; if (ifc.is_rs_idx !== 3'd4 || ifc.is_valid !== 1'b1 || ifc.stall_cnt !== 4'd3) begin
      failures++; $display("FAIL bp_release got idx=%0d st=%0d exp idx=4 st=3", ifc.is_rs_idx, ifc.stall_cnt); end
  endtask

  task automatic test_drain();
    step(8'h00, 8'hFF, 1, 0);
    checks++; if (got_clr !== 8'h00) begin failures++; $display("FAIL drain_clear got=%h exp=00", got_clr); end
    checks++; if (ifc.is_valid !== 1'b0 || ifc.is_packet !== e.pkt) begin
      failures++; $display("FAIL drain got v=%b exp v=0", ifc.is_valid); end
  endtask

  task automatic test_squash();
    do_reset();
    step(8'h02, 8'h02, 1, 0);
    step(8'h02, 8'h02, 1, 1);
    checks++; if (got_clr !== 8'h00) begin failures++; $display("FAIL squash_clear got=%h exp=00", got_clr); end
    checks++; if (ifc.is_valid !== 1'b0 || ifc.is_rs_idx !== 3'd1 || ifc.is_packet !== pk[1]) begin
      failures++; $display("FAIL squash_state got v=%b idx=%0d exp v=0 idx=1", ifc.is_valid, ifc.is_rs_idx); end
    // rr stayed at 2, so 2 beats 1
    step(8'h06, 8'h06, 1, 0);
    checks++; if (got_clr !== 8'h04) begin failures++; $display("FAIL squash_rr got=%h exp=04", got_clr); end
  endtask

  task automatic test_saturate();
    do_reset();
    step(8'h01, 8'h01, 1, 0);
    for (int i = 0; i < 18; i++) begin
      step(8'h00, 8'h00, 0, 0);
      checks++; if (ifc.stall_cnt !== e.st || ifc.is_valid !== 1'b1) begin
        failures++; $display("FAIL sat[%0d] got=%0d exp=%0d", i, ifc.stall_cnt, e.st); end
    end
    checks++; if (ifc.stall_cnt !== 4'hF) begin failures++; $display("FAIL sat_final got=%0d exp=15", ifc.stall_cnt); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 300; i++) begin
      if (i % 50 == 0) set_pkts();
      step(NUM_RS'($urandom), NUM_RS'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      checks++; if (got_clr !== e.clr) begin failures++; $display("FAIL rnd_clear[%0d] got=%h exp=%h", i, got_clr, e.clr); end
      checks++; if (ifc.is_valid !== e.v || ifc.is_rs_idx !== e.idx || ifc.is_packet !== e.pkt || ifc.stall_cnt !== e.st) begin
        failures++; $display("FAIL rnd_issue[%0d] got v=%b idx=%0d st=%0d exp v=%b idx=%0d st=%0d",
          i, ifc.is_valid, ifc.is_rs_idx, ifc.stall_cnt, e.v, e.idx, e.st); end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    step(8'h08, 8'h08, 1, 0);
    for (int i = 0; i < 5; i++) step(8'h00, 8'h00, 0, 0);
    checks++; if (ifc.is_valid !== 1'b1 || ifc.stall_cnt !== 4'd5) begin
      failures++; $display("FAIL async_pre got v=%b st=%0d exp v=1 st=5", ifc.is_valid, ifc.stall_cnt); end
    ifc.rs_busy = 8'hFF; ifc.rs_ready = 8'hFF; ifc.fu_ready = 1;
    #2;
    reset = 0;
    #1;
    checks++; if (ifc.is_valid !== 1'b0 || ifc.stall_cnt !== '0 || ifc.is_packet !== '0 || ifc.rs_clear !== '0) begin
      failures++; $display("FAIL async_reset got v=%b st=%0d clr=%h exp v=0 st=0 clr=00",
        ifc.is_valid, ifc.stall_cnt, ifc.rs_clear); end
    do_reset();
  endtask

  initial begin
    checks = 0; failures = 0;
    reset = 0;
    ifc.rs_busy = '0; ifc.rs_ready = '0; ifc.fu_ready = 0; ifc.squash = 0;
    set_pkts();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_squash();
    test_saturate();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
